// File: rtl/coin_dispenser_pkg.sv
// Shared definitions for the coin dispenser: FSM states, coin values,
// error codes and the amount width.
package coin_dispenser_pkg;

    localparam int unsigned AMT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_EJECT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);

    localparam logic [1:0] ERRC_NONE   = 2'b00;
    localparam logic [1:0] ERRC_AMOUNT = 2'b01;
    localparam logic [1:0] ERRC_SHORT  = 2'b10;
    localparam logic [1:0] ERRC_JAM    = 2'b11;

    // An amount is payable only if it is a whole number of nickels.
    function automatic logic amount_ok(input logic [AMT_W-1:0] a);
        return (a % VAL_N) == '0;
    endfunction

endpackage

// File: rtl/coin_dispenser_hop_timer.sv
// hop_timer: bounded wait counter for the hopper acknowledge.
// Ports:
//   clk, rstn : clock, async active-low reset
//   clear     : force the count to zero (held while not ejecting)
//   en        : count one unacknowledged cycle
//   expire    : current cycle is the ACK_TMO-th unacknowledged cycle
module hop_timer #(
    parameter int unsigned ACK_TMO = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int unsigned TW = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);
    localparam logic [TW-1:0] CNT_MAX  = TW'(ACK_TMO);
    localparam logic [TW-1:0] CNT_LAST = TW'(ACK_TMO - 1);

    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;

    // Saturating count; it only ever runs while the FSM sits in EJECT.
    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + TW'(1);
        end
    end

    // expire is registered alongside the count so it tracks cnt == ACK_TMO-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            expire <= (cnt_nxt == CNT_LAST);
        end
    end

endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser: pays out change greedily (quarter, dime, nickel) from a
// loadable inventory, one coin per hopper handshake.
// Ports:
//   clk, rstn                : clock, async active-low reset
//   req, amount              : change request and amount in cents (IDLE only)
//   load, q_load/d_load/n_load : inventory load strobe and counts (IDLE only)
//   hop_ack                  : hopper confirms one coin ejected
//   q_out/d_out/n_out        : eject command, held until ack or timeout
//   busy, done, err          : status; done/err are one-cycle pulses
//   err_code                 : 01 bad amount, 10 shortfall, 11 jam
//   remaining                : cents still owed
//   q_cnt/d_cnt/n_cnt        : current inventory
module coin_dispenser
    import coin_dispenser_pkg::*;
#(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned ACK_TMO = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             load,
    input  logic [CNT_W-1:0] q_load,
    input  logic [CNT_W-1:0] d_load,
    input  logic [CNT_W-1:0] n_load,
    input  logic             hop_ack,
    output logic             q_out,
    output logic             d_out,
    output logic             n_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] n_cnt
);

    state_t state, state_nxt;

    logic             bad_amt, bad_amt_nxt;
    logic             q_out_nxt, d_out_nxt, n_out_nxt;
    logic             busy_nxt, done_nxt, err_nxt;
    logic [1:0]       err_code_nxt;
    logic [AMT_W-1:0] remaining_nxt;
    logic [CNT_W-1:0] q_cnt_nxt, d_cnt_nxt, n_cnt_nxt;

    logic tmr_clear;
    logic tmr_en;
    logic tmr_expire;

    // Timer is held clear outside EJECT so it starts from zero on entry.
    assign tmr_clear = (state != S_EJECT);
    assign tmr_en    = (state == S_EJECT) && !hop_ack;

    hop_timer #(
        .ACK_TMO (ACK_TMO)
    ) u_hop_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        bad_amt_nxt   = bad_amt;
        q_out_nxt     = q_out;
        d_out_nxt     = d_out;
        n_out_nxt     = n_out;
        err_code_nxt  = err_code;
        remaining_nxt = remaining;
        q_cnt_nxt     = q_cnt;
        d_cnt_nxt     = d_cnt;
        n_cnt_nxt     = n_cnt;

        unique case (state)
            S_IDLE: begin
                // A request takes precedence over a simultaneous load.
                if (req) begin
                    remaining_nxt = amount;
                    err_code_nxt  = ERRC_NONE;
                    bad_amt_nxt   = !amount_ok(amount);
                    state_nxt     = S_CHECK;
                end else if (load) begin
                    q_cnt_nxt = q_load;
                    d_cnt_nxt = d_load;
                    n_cnt_nxt = n_load;
                end
            end

            S_CHECK: begin
                // Greedy pick; a coin type is eligible only with stock left.
                if (bad_amt) begin
                    err_code_nxt = ERRC_AMOUNT;
                    state_nxt    = S_ERR;
                end else if ((remaining >= VAL_Q) && (q_cnt != '0)) begin
                    q_out_nxt = 1'b1;
                    state_nxt = S_EJECT;
                end else if ((remaining >= VAL_D) && (d_cnt != '0)) begin
                    d_out_nxt = 1'b1;
                    state_nxt = S_EJECT;
                end else if ((remaining >= VAL_N) && (n_cnt != '0)) begin
                    n_out_nxt = 1'b1;
                    state_nxt = S_EJECT;
                end else if (remaining == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    err_code_nxt = ERRC_SHORT;
                    state_nxt    = S_ERR;
                end
            end

            S_EJECT: begin
                // An ack on the last allowed cycle still counts as a payout.
                if (hop_ack) begin
                    if (q_out) begin
                        remaining_nxt = remaining - VAL_Q;
                        q_cnt_nxt     = q_cnt - CNT_W'(1);
                    end else if (d_out) begin
                        remaining_nxt = remaining - VAL_D;
                        d_cnt_nxt     = d_cnt - CNT_W'(1);
                    end else if (n_out) begin
                        remaining_nxt = remaining - VAL_N;
                        n_cnt_nxt     = n_cnt - CNT_W'(1);
                    end
                    q_out_nxt = 1'b0;
                    d_out_nxt = 1'b0;
                    n_out_nxt = 1'b0;
                    state_nxt = S_CHECK;
                end else if (tmr_expire) begin
                    q_out_nxt    = 1'b0;
                    d_out_nxt    = 1'b0;
                    n_out_nxt    = 1'b0;
                    err_code_nxt = ERRC_JAM;
                    state_nxt    = S_ERR;
                end
            end

            S_DONE: state_nxt = S_IDLE;

            S_ERR: state_nxt = S_IDLE;

            default: state_nxt = S_IDLE;
        endcase

        // Status flags are registered copies of the state being entered.
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        err_nxt  = (state_nxt == S_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            bad_amt   <= 1'b0;
            q_out     <= 1'b0;
            d_out     <= 1'b0;
            n_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERRC_NONE;
            remaining <= '0;
            q_cnt     <= '0;
            d_cnt     <= '0;
            n_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            bad_amt   <= bad_amt_nxt;
            q_out     <= q_out_nxt;
            d_out     <= d_out_nxt;
            n_out     <= n_out_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            err_code  <= err_code_nxt;
            remaining <= remaining_nxt;
            q_cnt     <= q_cnt_nxt;
            d_cnt     <= d_cnt_nxt;
            n_cnt     <= n_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: directed scenarios followed by random requests,
// checked through an expectation queue drained by a monitor.
module tb_coin_dispenser;

    localparam int CNT_W   = 6;
    localparam int ACK_TMO = 10;

    logic             clk;
    logic             rstn;
    logic             req;
    logic [7:0]       amount;
    logic             load;
    logic [CNT_W-1:0] q_load, d_load, n_load;
    logic             hop_ack;
    logic             q_out, d_out, n_out;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [7:0]       remaining;
    logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;

    coin_dispenser #(
        .CNT_W   (CNT_W),
        .ACK_TMO (ACK_TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .amount    (amount),
        .load      (load),
        .q_load    (q_load),
        .d_load    (d_load),
        .n_load    (n_load),
        .hop_ack   (hop_ack),
        .q_out     (q_out),
        .d_out     (d_out),
        .n_out     (n_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .remaining (remaining),
        .q_cnt     (q_cnt),
        .d_cnt     (d_cnt),
        .n_cnt     (n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 coin ejected, 1 done, 2 err
    typedef struct {
        int kind;
        int coin;
        int code;
        int rem;
        int q;
        int d;
        int n;
        int lat;
        bit chk_len;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    int mq = 0, md = 0, mn = 0;
    int last_code = 0;
    int req_cyc = 0;
    int jam_target = -1;
    int coins_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int kind, input int coin, input int code,
                                input int rem, input int lat, input bit chk_len);
        exp_t e;
        e.kind = kind; e.coin = coin; e.code = code; e.rem = rem;
        e.q = mq; e.d = md; e.n = mn; e.lat = lat; e.chk_len = chk_len;
        return e;
    endfunction

    // Reference: greedy change-making over the model inventory.
    task automatic model_req(input int amt, input int jam_k);
        int rem;
        int k;
        int c;
        if (amt % 5 != 0) begin
            exp_q.push_back(mk(2, 0, 1, amt, 2, 1'b0));
            last_code = 1;
            return;
        end
        rem = amt;
        k   = 0;
        forever begin
            if (rem >= 25 && mq > 0)      c = 0;
            else if (rem >= 10 && md > 0) c = 1;
            else if (rem >= 5 && mn > 0)  c = 2;
            else if (rem == 0) begin
                exp_q.push_back(mk(1, 0, 0, 0, -1, 1'b0));
                last_code = 0;
                return;
            end else begin
                exp_q.push_back(mk(2, 0, 2, rem, -1, 1'b0));
                last_code = 2;
                return;
            end
            exp_q.push_back(mk(0, c, 0, rem, -1, 1'b0));
            if (k == jam_k) begin
                exp_q.push_back(mk(2, 0, 3, rem, -1, 1'b1));
                last_code = 3;
                return;
            end
            case (c)
                0: begin rem -= 25; mq--; end
                1: begin rem -= 10; md--; end
                default: begin rem -= 5; mn--; end
            endcase
            k++;
        end
    endtask

    // Hopper: acks each coin after 0..3 cycles unless it is the jammed one;
    // occasionally pulses a stray ack while no coin is requested.
    initial begin
        int  lat;
        int  waited;
        bit  inflight;
        bit  jam_now;
        hop_ack  = 1'b0;
        inflight = 1'b0;
        jam_now  = 1'b0;
        lat      = 0;
        waited   = 0;
        forever begin
            @(posedge clk);
            #1;
            hop_ack = 1'b0;
            if (q_out || d_out || n_out) begin
                if (!inflight) begin
                    inflight = 1'b1;
                    waited   = 0;
                    lat      = int'($urandom_range(0, 3));
                    jam_now  = (coins_total == jam_target);
                    coins_total++;
                end
                if (!jam_now && waited == lat) hop_ack = 1'b1;
                waited++;
            end else begin
                inflight = 1'b0;
                if ($urandom_range(0, 7) == 0) hop_ack = 1'b1;
            end
        end
    end

    // Monitor: pops an expectation on each coin-line rise and each done/err.
    initial begin
        logic [2:0] prev;
        logic [2:0] cur;
        int         out_len;
        int         last_len;
        int         coin;
        exp_t       e;
        prev     = '0;
        out_len  = 0;
        last_len = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev    = '0;
                out_len = 0;
                continue;
            end
            cur = {q_out, d_out, n_out};
            if (cur != 3'b000) begin
                out_len++;
                chk("out_onehot", $countones(cur), 1);
            end
            if (cur != 3'b000 && prev == 3'b000) begin
                coin = (cur[2]) ? 0 : (cur[1]) ? 1 : 2;
                if (exp_q.size() == 0) begin
                    chk("unexpected_coin", coin, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 0, e.kind);
                    chk("coin_type", coin, e.coin);
                    chk("rem_at_eject", int'(remaining), e.rem);
                end
            end
            if (cur == 3'b000 && prev != 3'b000) begin
                last_len = out_len;
                out_len  = 0;
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_term", done ? 1 : 2, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("term_kind", done ? 1 : 2, e.kind);
                    chk("term_both", int'(done && err), 0);
                    chk("term_busy", int'(busy), 1);
                    if (err) chk("err_code", int'(err_code), e.code);
                    chk("remaining", int'(remaining), e.rem);
                    chk("q_cnt", int'(q_cnt), e.q);
                    chk("d_cnt", int'(d_cnt), e.d);
                    chk("n_cnt", int'(n_cnt), e.n);
                    if (e.lat >= 0) chk("err_latency", cyc - req_cyc, e.lat);
                    if (e.chk_len) chk("jam_out_len", last_len, ACK_TMO);
                end
            end
            prev = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int q, input int d, input int n);
        load   = 1'b1;
        q_load = CNT_W'(q);
        d_load = CNT_W'(d);
        n_load = CNT_W'(n);
        tick();
        load = 1'b0;
        mq = q; md = d; mn = n;
    endtask

    // Issues a request; with_load also raises load (which must be ignored).
    task automatic do_req(input int amt, input int jam_k, input bit with_load);
        jam_target = (jam_k < 0) ? -1 : coins_total + jam_k;
        model_req(amt, jam_k);
        req     = 1'b1;
        amount  = 8'(amt);
        req_cyc = cyc;
        if (with_load) begin
            load   = 1'b1;
            q_load = CNT_W'($urandom_range(10, 20));
            d_load = CNT_W'($urandom_range(10, 20));
            n_load = CNT_W'($urandom_range(10, 20));
        end
        tick();
        req  = 1'b0;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        chk("wait_idle_bound", int'(k < 3000), 1);
        jam_target = -1;
        tick();
        chk("err_code_hold", int'(err_code), last_code);
        chk("busy_idle", int'(busy), 0);
    endtask

    // Fires a request and a load while a coin is being ejected.
    task automatic poke_while_busy();
        int k;
        k = 0;
        while (!(q_out || d_out || n_out) && busy && k < 50) begin
            tick();
            k++;
        end
        if (busy) begin
            req    = 1'b1;
            amount = 8'd5;
            load   = 1'b1;
            q_load = CNT_W'(30);
            d_load = CNT_W'(30);
            n_load = CNT_W'(30);
            tick();
            req  = 1'b0;
            load = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, int'({q_out, d_out, n_out}), 0);
        chk({tag, "_flags"}, int'({busy, done, err}), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
        chk({tag, "_cnts"}, int'(q_cnt) + int'(d_cnt) + int'(n_cnt), 0);
    endtask

    initial begin
        int amt;
        rstn   = 1'b0;
        req    = 1'b0;
        amount = '0;
        load   = 1'b0;
        q_load = '0;
        d_load = '0;
        n_load = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Exact change with mixed coins.
        do_load(2, 1, 1);
        chk("load_q", int'(q_cnt), 2);
        do_req(65, -1, 1'b0);
        wait_idle();

        // Shortfall after one quarter.
        do_load(1, 0, 0);
        do_req(30, -1, 1'b0);
        wait_idle();

        // Amount not a multiple of 5.
        do_load(3, 3, 3);
        do_req(27, -1, 1'b0);
        wait_idle();

        // Zero amount completes with no coins.
        do_req(0, -1, 1'b0);
        wait_idle();

        // Jam on the first coin.
        do_load(2, 0, 0);
        do_req(25, 0, 1'b0);
        wait_idle();

        // Request with simultaneous load, then stray request/load while busy.
        do_load(1, 1, 1);
        do_req(15, -1, 1'b1);
        poke_while_busy();
        wait_idle();

        // Reset in the middle of an ejection.
        do_load(3, 0, 0);
        do_req(25, -1, 1'b0);
        begin
            int k;
            k = 0;
            while (!q_out && k < 20) begin
                tick();
                k++;
            end
            chk("q_out_before_reset", int'(q_out), 1);
        end
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        exp_q.delete();
        mq = 0; md = 0; mn = 0;
        last_code = 0;
        jam_target = -1;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            if (i == 0 || $urandom_range(0, 2) == 0)
                do_load(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 255));
            else                           amt = 5 * int'($urandom_range(0, 51));
            do_req(amt, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                   $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) poke_while_busy();
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
